// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
//   Multi-cycle radix-2 multiply/divide engine feeding the HI/LO register stage.
//   One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
//   The pipeline stalls while busy is high and writes HI/LO on the done pulse.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : operation request, sampled only in IDLE or DONE
//   flush   : synchronous abort of the operation in flight
//   func    : operation code; only MULU/MULS/DIVU/DIVS are accepted
//   data1   : multiplicand / dividend (rs)
//   data2   : multiplier / divisor (rt)
//   busy    : operation in flight (RUN or FIX)
//   done    : one-cycle pulse, res_hi/res_lo valid
//   res_hi  : product[2W-1:W] or remainder
//   res_lo  : product[W-1:0] or quotient
// -----------------------------------------------------------------------------
module alu_muldiv_seq #(
   parameter int DATA_W  = 32,
   parameter int COUNT_W = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              flush,
   input  logic [3:0]        func,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] res_hi,
   output logic [DATA_W-1:0] res_lo
);

   localparam logic [3:0] FUNC_MULU = 4'h8;
   localparam logic [3:0] FUNC_MULS = 4'h9;
   localparam logic [3:0] FUNC_DIVU = 4'hA;
   localparam logic [3:0] FUNC_DIVS = 4'hB;

   localparam logic [COUNT_W-1:0] COUNT_INIT = COUNT_W'(DATA_W);
   localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic [COUNT_W-1:0]  count_reg;
   logic                is_div_reg;
   logic                neg_a_reg;
   logic                neg_b_reg;
   logic                div_zero_reg;
   logic [DATA_W-1:0]   b_reg;
   logic [DATA_W-1:0]   acc_hi_reg;
   logic [DATA_W-1:0]   acc_lo_reg;
   logic [DATA_W-1:0]   res_hi_reg;
   logic [DATA_W-1:0]   res_lo_reg;

   // Request decode
   logic                func_is_mul;
   logic                func_is_div;
   logic                func_is_signed;
   logic                accept;
   logic                neg_a_next;
   logic                neg_b_next;
   logic [DATA_W-1:0]   mag_a_next;
   logic [DATA_W-1:0]   mag_b_next;

   // Iteration and sign-fix datapath
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_diff;
   logic                div_ge;
   logic [DATA_W-1:0]   step_hi;
   logic [DATA_W-1:0]   step_lo;
   logic [2*DATA_W-1:0] prod_raw;
   logic [DATA_W-1:0]   fix_hi;
   logic [DATA_W-1:0]   fix_lo;

   assign func_is_mul    = (func == FUNC_MULU) || (func == FUNC_MULS);
   assign func_is_div    = (func == FUNC_DIVU) || (func == FUNC_DIVS);
   assign func_is_signed = (func == FUNC_MULS) || (func == FUNC_DIVS);

   // flush outranks start, and start is only looked at when no operation is in flight
   assign accept = start && (func_is_mul || func_is_div) && !flush &&
                   ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

   // Signed ops run on magnitudes; |MIN_INT| = 2^(W-1) still fits the unsigned datapath
   always_comb begin
      neg_a_next = func_is_signed && data1[DATA_W-1];
      neg_b_next = func_is_signed && data2[DATA_W-1];
      mag_a_next = neg_a_next ? (~data1 + 1'b1) : data1;
      mag_b_next = neg_b_next ? (~data2 + 1'b1) : data2;
   end

   // One iteration. Multiply: {acc_hi,acc_lo} holds {partial product, remaining multiplier}
   // and shifts right. Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out
   // at the top and the quotient bits in at the bottom.
   always_comb begin
      mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, b_reg} : '0);
      div_shift = {acc_hi_reg, acc_lo_reg[DATA_W-1]};
      div_diff  = div_shift - {1'b0, b_reg};
      div_ge    = (div_shift >= {1'b0, b_reg});
      step_hi   = mul_sum[DATA_W:1];
      step_lo   = {mul_sum[0], acc_lo_reg[DATA_W-1:1]};
      if (is_div_reg) begin
         step_hi = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
         step_lo = {acc_lo_reg[DATA_W-2:0], div_ge};
      end
   end

   // Sign correction. The remainder follows the dividend's sign. A zero divisor makes the
   // restoring loop yield quotient=all ones and remainder=|data1|, so only the quotient needs
   // forcing; negating the remainder then restores the original data1.
   always_comb begin
      prod_raw = {acc_hi_reg, acc_lo_reg};
      if (neg_a_reg ^ neg_b_reg) begin
         prod_raw = ~prod_raw + 1'b1;
      end
      fix_hi = prod_raw[2*DATA_W-1:DATA_W];
      fix_lo = prod_raw[DATA_W-1:0];
      if (is_div_reg) begin
         fix_hi = neg_a_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
         if (div_zero_reg) begin
            fix_lo = '1;
         end else if (neg_a_reg ^ neg_b_reg) begin
            fix_lo = ~acc_lo_reg + 1'b1;
         end else begin
            fix_lo = acc_lo_reg;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg    <= '0;
         is_div_reg   <= 1'b0;
         neg_a_reg    <= 1'b0;
         neg_b_reg    <= 1'b0;
         div_zero_reg <= 1'b0;
         b_reg        <= '0;
         acc_hi_reg   <= '0;
         acc_lo_reg   <= '0;
         res_hi_reg   <= '0;
         res_lo_reg   <= '0;
      end else if (accept) begin
         count_reg    <= COUNT_INIT;
         is_div_reg   <= func_is_div;
         neg_a_reg    <= neg_a_next;
         neg_b_reg    <= neg_b_next;
         div_zero_reg <= (data2 == '0);
         b_reg        <= mag_b_next;
         acc_hi_reg   <= '0;
         acc_lo_reg   <= mag_a_next;
      end else if (state_reg == ST_RUN) begin
         count_reg    <= count_reg - 1'b1;
         acc_hi_reg   <= step_hi;
         acc_lo_reg   <= step_lo;
      end else if ((state_reg == ST_FIX) && !flush) begin
         // A flushed operation never reaches the result registers
         res_hi_reg   <= fix_hi;
         res_lo_reg   <= fix_lo;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (flush)                        state_next = ST_IDLE;
            else if (count_reg == COUNT_LAST) state_next = ST_FIX;
         end
         ST_FIX: begin
            state_next = flush ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            state_next = accept ? ST_RUN : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         ST_RUN,
         ST_FIX:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   assign res_hi = res_hi_reg;
   assign res_lo = res_lo_reg;

endmodule
